// File: rtl/pkg_hamming.sv
// Shared types and helpers for the SECDED Hamming(8,4) decoder sequencer.
package pkg_hamming;

    typedef enum logic [1:0] {
        ESPERA   = 2'd0,
        APLICAR  = 2'd1,
        ENTREGAR = 2'd2
    } estado_t;

    // Bit 7 of the coded word carries the overall (even) parity.
    localparam int PARIDAD_GLOBAL = 7;

    typedef struct packed {
        logic [7:0] corregida;
        logic       err_simple;
        logic       err_doble;
    } resultado_t;

    // Data nibble sits at word bits {6,5,4,2}.
    function automatic logic [3:0] extraer_dato(input logic [7:0] w);
        return {w[6], w[5], w[4], w[2]};
    endfunction

    // SECDED decision: syn names the faulty position (1..7), st says the
    // overall parity is broken. Parity broken with a zero syndrome means
    // only the parity bit itself flipped; syndrome set with parity intact
    // means two bits flipped, which cannot be repaired.
    function automatic resultado_t corregir(input logic [7:0] recibido,
                                            input logic [2:0] syn,
                                            input logic       st);
        resultado_t r;
        r.corregida  = recibido;
        r.err_simple = 1'b0;
        r.err_doble  = 1'b0;
        if (st) begin
            r.err_simple = 1'b1;
            if (syn != 3'd0)
                r.corregida[syn - 3'd1] = ~recibido[syn - 3'd1];
            else
                r.corregida[PARIDAD_GLOBAL] = ~recibido[PARIDAD_GLOBAL];
        end else if (syn != 3'd0) begin
            r.err_doble = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/contador_saturado.sv
// Statistics counter that sticks at all-ones; clear wins over increment.
module contador_saturado #(
    parameter int CNT_W = 16
) (
    input  logic             reloj,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cuenta
);

    // Count events, holding at the top value instead of wrapping.
    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n)
            cuenta <= '0;
        else if (clr)
            cuenta <= '0;
        else if (inc && (cuenta != '1))
            cuenta <= cuenta + CNT_W'(1);
    end

endmodule

// File: rtl/control_decodificador.sv
// Sequencer around the Hamming(8,4) SECDED decoder: accepts a word, feeds the
// external decoder from registers, captures and corrects its verdict, hands
// the result out over a valid/ready handshake and keeps error statistics.
module control_decodificador
    import pkg_hamming::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             reloj,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_palabra,
    input  logic [3:0]       in_dato_error,
    output logic [7:0]       dec_palabra,
    output logic [3:0]       dec_dato_error,
    input  logic [7:0]       dec_recibido,
    input  logic             dec_s1,
    input  logic             dec_s2,
    input  logic             dec_s3,
    input  logic             dec_st,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_corregida,
    output logic [3:0]       out_dato,
    output logic             out_err_simple,
    output logic             out_err_doble,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_palabras,
    output logic [CNT_W-1:0] cnt_simple,
    output logic [CNT_W-1:0] cnt_doble
);

    estado_t    r_estado;
    estado_t    w_estado_sig;
    logic [7:0] r_dec_palabra;
    logic [3:0] r_dec_dato_error;
    logic [7:0] r_corregida;
    logic       r_err_simple;
    logic       r_err_doble;
    logic       w_acepta;
    logic       w_captura;
    logic       w_entrega;
    resultado_t w_resultado;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n)
            r_estado <= ESPERA;
        else
            r_estado <= w_estado_sig;
    end

    // Next state and handshake strobes.
    // NOTE: every output is defaulted first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        w_estado_sig = r_estado;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_acepta     = 1'b0;
        w_captura    = 1'b0;
        w_entrega    = 1'b0;
        case (r_estado)
            ESPERA: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_acepta     = 1'b1;
                    w_estado_sig = APLICAR;
                end
            end
            APLICAR: begin
                w_captura    = 1'b1;
                w_estado_sig = ENTREGAR;
            end
            ENTREGAR: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_entrega    = 1'b1;
                    w_estado_sig = ESPERA;
                end
            end
            default: w_estado_sig = ESPERA;
        endcase
    end

    // Operand registers driving the decoder; loaded only on acceptance.
    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            r_dec_palabra    <= '0;
            r_dec_dato_error <= '0;
        end else if (w_acepta) begin
            r_dec_palabra    <= in_palabra;
            r_dec_dato_error <= in_dato_error;
        end
    end

    // Correction applied to the settled decoder outputs.
    always_comb begin
        w_resultado = corregir(dec_recibido, {dec_s3, dec_s2, dec_s1}, dec_st);
    end

    // Result registers, captured at the end of APLICAR and held while the
    // consumer stalls.
    always_ff @(posedge reloj or negedge rst_n) begin
        if (!rst_n) begin
            r_corregida  <= '0;
            r_err_simple <= 1'b0;
            r_err_doble  <= 1'b0;
        end else if (w_captura) begin
            r_corregida  <= w_resultado.corregida;
            r_err_simple <= w_resultado.err_simple;
            r_err_doble  <= w_resultado.err_doble;
        end
    end

    assign dec_palabra    = r_dec_palabra;
    assign dec_dato_error = r_dec_dato_error;
    assign out_corregida  = r_corregida;
    assign out_dato       = extraer_dato(r_corregida);
    assign out_err_simple = r_err_simple;
    assign out_err_doble  = r_err_doble;

    // Statistics move only on the result transfer edge.
    contador_saturado #(.CNT_W(CNT_W)) u_cnt_palabras (
        .reloj  (reloj),
        .rst_n  (rst_n),
        .inc    (w_entrega),
        .clr    (clr_cnt),
        .cuenta (cnt_palabras)
    );

    contador_saturado #(.CNT_W(CNT_W)) u_cnt_simple (
        .reloj  (reloj),
        .rst_n  (rst_n),
        .inc    (w_entrega & r_err_simple),
        .clr    (clr_cnt),
        .cuenta (cnt_simple)
    );

    contador_saturado #(.CNT_W(CNT_W)) u_cnt_doble (
        .reloj  (reloj),
        .rst_n  (rst_n),
        .inc    (w_entrega & r_err_doble),
        .clr    (clr_cnt),
        .cuenta (cnt_doble)
    );

endmodule

// File: tb/tb_control_decodificador.sv
// Directed bench for control_decodificador. Two instances share stimulus:
// 'a' with 16-bit counters and 'b' with 2-bit counters to reach saturation.
module tb_control_decodificador;

    logic        reloj = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_palabra;
    logic [3:0]  in_dato_error;
    logic        out_ready;
    logic        clr_cnt;

    logic        a_in_ready, a_out_valid, a_err_simple, a_err_doble;
    logic        a_s1, a_s2, a_s3, a_st;
    logic [7:0]  a_dec_palabra, a_recibido, a_corregida;
    logic [3:0]  a_dec_dato_error, a_dato;
    logic [15:0] a_cnt_pal, a_cnt_sim, a_cnt_dob;

    logic        b_in_ready, b_out_valid, b_err_simple, b_err_doble;
    logic        b_s1, b_s2, b_s3, b_st;
    logic [7:0]  b_dec_palabra, b_recibido, b_corregida;
    logic [3:0]  b_dec_dato_error, b_dato;
    logic [1:0]  b_cnt_pal, b_cnt_sim, b_cnt_dob;

    int errors = 0;
    int checks = 0;

    always #5 reloj = ~reloj;

    // Stand-in for the external decoder: inserts the forced data bits into
    // positions {6,5,4,2} and computes the Hamming syndrome and overall parity.
    function automatic logic [11:0] decoder_stub(input logic [7:0] p, input logic [3:0] d);
        logic [7:0] r;
        logic s1, s2, s3, st;
        r  = {p[7], d[3], d[2], d[1], p[3], d[0], p[1:0]};
        s1 = r[0] ^ r[2] ^ r[4] ^ r[6];
        s2 = r[1] ^ r[2] ^ r[5] ^ r[6];
        s3 = r[3] ^ r[4] ^ r[5] ^ r[6];
        st = ^r;
        return {st, s3, s2, s1, r};
    endfunction

    assign {a_st, a_s3, a_s2, a_s1, a_recibido} = decoder_stub(a_dec_palabra, a_dec_dato_error);
    assign {b_st, b_s3, b_s2, b_s1, b_recibido} = decoder_stub(b_dec_palabra, b_dec_dato_error);

    control_decodificador #(.CNT_W(16)) dut_a (
        .reloj(reloj), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_palabra(in_palabra), .in_dato_error(in_dato_error),
        .dec_palabra(a_dec_palabra), .dec_dato_error(a_dec_dato_error),
        .dec_recibido(a_recibido), .dec_s1(a_s1), .dec_s2(a_s2), .dec_s3(a_s3), .dec_st(a_st),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_corregida(a_corregida), .out_dato(a_dato),
        .out_err_simple(a_err_simple), .out_err_doble(a_err_doble),
        .clr_cnt(clr_cnt),
        .cnt_palabras(a_cnt_pal), .cnt_simple(a_cnt_sim), .cnt_doble(a_cnt_dob)
    );

    control_decodificador #(.CNT_W(2)) dut_b (
        .reloj(reloj), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_palabra(in_palabra), .in_dato_error(in_dato_error),
        .dec_palabra(b_dec_palabra), .dec_dato_error(b_dec_dato_error),
        .dec_recibido(b_recibido), .dec_s1(b_s1), .dec_s2(b_s2), .dec_s3(b_s3), .dec_st(b_st),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_corregida(b_corregida), .out_dato(b_dato),
        .out_err_simple(b_err_simple), .out_err_doble(b_err_doble),
        .clr_cnt(clr_cnt),
        .cnt_palabras(b_cnt_pal), .cnt_simple(b_cnt_sim), .cnt_doble(b_cnt_dob)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one word, confirm acceptance, then wait (bounded) for out_valid.
    task automatic send(input logic [7:0] p, input logic [3:0] d, input string tag);
        int n;
        @(negedge reloj);
        in_valid      = 1'b1;
        in_palabra    = p;
        in_dato_error = d;
        check({tag, " in_ready"}, 32'(a_in_ready), 32'd1);
        @(posedge reloj);
        #1;
        in_valid = 1'b0;
        check({tag, " dec_palabra"}, 32'(a_dec_palabra), 32'(p));
        check({tag, " dec_dato_error"}, 32'(a_dec_dato_error), 32'(d));
        check({tag, " no early valid"}, 32'(a_out_valid), 32'd0);
        n = 0;
        while (!a_out_valid && n < 2) begin
            @(posedge reloj);
            #1;
            n++;
        end
        check({tag, " valid by k+2"}, 32'(a_out_valid), 32'd1);
        check({tag, " valid b"}, 32'(b_out_valid), 32'd1);
    endtask

    task automatic expect_result(input logic [7:0] corr, input logic [3:0] dato,
                                 input logic s, input logic d, input string tag);
        check({tag, " corregida"}, 32'(a_corregida), 32'(corr));
        check({tag, " dato"}, 32'(a_dato), 32'(dato));
        check({tag, " simple"}, 32'(a_err_simple), 32'(s));
        check({tag, " doble"}, 32'(a_err_doble), 32'(d));
        check({tag, " corregida b"}, 32'(b_corregida), 32'(corr));
        check({tag, " flags b"}, 32'({b_err_simple, b_err_doble, b_dato}), 32'({s, d, dato}));
    endtask

    task automatic transfer(input logic clr, input string tag);
        @(negedge reloj);
        out_ready = 1'b1;
        clr_cnt   = clr;
        @(posedge reloj);
        #1;
        out_ready = 1'b0;
        clr_cnt   = 1'b0;
        check({tag, " valid drops"}, 32'(a_out_valid), 32'd0);
        check({tag, " ready back"}, 32'({a_in_ready, b_in_ready}), 32'b11);
    endtask

    task automatic counts(input int p, input int s, input int d,
                          input int p2, input int s2, input int d2, input string tag);
        check({tag, " cnt_palabras"}, 32'(a_cnt_pal), p);
        check({tag, " cnt_simple"}, 32'(a_cnt_sim), s);
        check({tag, " cnt_doble"}, 32'(a_cnt_dob), d);
        check({tag, " w2 cnt_palabras"}, 32'(b_cnt_pal), p2);
        check({tag, " w2 cnt_simple"}, 32'(b_cnt_sim), s2);
        check({tag, " w2 cnt_doble"}, 32'(b_cnt_dob), d2);
    endtask

    initial begin
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_palabra    = 8'h00;
        in_dato_error = 4'h0;
        out_ready     = 1'b0;
        clr_cnt       = 1'b0;

        // Reset state.
        repeat (2) @(posedge reloj);
        #1;
        check("reset in_ready", 32'(a_in_ready), 32'd1);
        check("reset out_valid", 32'(a_out_valid), 32'd0);
        check("reset dec_palabra", 32'(a_dec_palabra), 32'h00);
        check("reset corregida", 32'(a_corregida), 32'h00);
        check("reset flags", 32'({a_err_simple, a_err_doble}), 32'd0);
        counts(0, 0, 0, 0, 0, 0, "reset");
        @(negedge reloj);
        rst_n = 1'b1;

        // Clean word.
        send(8'h55, 4'hB, "clean");
        expect_result(8'h55, 4'hB, 1'b0, 1'b0, "clean");
        transfer(1'b0, "clean");
        counts(1, 0, 0, 1, 0, 0, "clean");

        // Single data error at position 3.
        send(8'h55, 4'hA, "single");
        expect_result(8'h55, 4'hB, 1'b1, 1'b0, "single");
        transfer(1'b0, "single");
        counts(2, 1, 0, 2, 1, 0, "single");

        // Overall parity bit flipped only.
        send(8'hD5, 4'hB, "parity");
        expect_result(8'h55, 4'hB, 1'b1, 1'b0, "parity");
        transfer(1'b0, "parity");
        counts(3, 2, 0, 3, 2, 0, "parity");

        // Double error: detected, left uncorrected.
        send(8'h55, 4'h8, "double");
        expect_result(8'h41, 4'h8, 1'b0, 1'b1, "double");
        transfer(1'b0, "double");
        counts(4, 2, 1, 3, 2, 1, "double");

        // Backpressure: consumer stalls for 5 cycles.
        send(8'h55, 4'hA, "bp");
        for (int i = 0; i < 5; i++) begin
            @(posedge reloj);
            #1;
            check("bp out_valid held", 32'(a_out_valid), 32'd1);
            check("bp corregida held", 32'(a_corregida), 32'h55);
            check("bp simple held", 32'(a_err_simple), 32'd1);
            check("bp in_ready low", 32'(a_in_ready), 32'd0);
            check("bp cnt frozen", 32'(a_cnt_pal), 32'd4);
        end
        transfer(1'b0, "bp");
        counts(5, 3, 1, 3, 3, 1, "bp");

        // More single errors: narrow counters stay saturated.
        send(8'h55, 4'hA, "sat1");
        expect_result(8'h55, 4'hB, 1'b1, 1'b0, "sat1");
        transfer(1'b0, "sat1");
        counts(6, 4, 1, 3, 3, 1, "sat1");
        send(8'hD5, 4'hB, "sat2");
        transfer(1'b0, "sat2");
        counts(7, 5, 1, 3, 3, 1, "sat2");

        // Clear coincident with a transfer wins over the increment.
        send(8'h55, 4'hA, "clr");
        transfer(1'b1, "clr");
        counts(0, 0, 0, 0, 0, 0, "clr");

        // Reset while in APLICAR: the in-flight word must vanish.
        @(negedge reloj);
        in_valid      = 1'b1;
        in_palabra    = 8'h55;
        in_dato_error = 4'hA;
        @(posedge reloj);
        #1;
        in_valid = 1'b0;
        check("rstmid in APLICAR", 32'({a_in_ready, a_out_valid}), 32'b00);
        rst_n = 1'b0;
        #1;
        check("rstmid ready in reset", 32'(a_in_ready), 32'd1);
        check("rstmid valid in reset", 32'(a_out_valid), 32'd0);
        check("rstmid corregida cleared", 32'(a_corregida), 32'h00);
        @(negedge reloj);
        @(negedge reloj);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge reloj);
            #1;
            check("rstmid no valid", 32'({a_out_valid, b_out_valid}), 32'b00);
            check("rstmid ready", 32'(a_in_ready), 32'd1);
        end
        counts(0, 0, 0, 0, 0, 0, "rstmid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
